// File: rtl/seg_serial_tx.sv
// seg_serial_tx: decodes a frame of hex digits to 7-seg bytes and shifts it MSB-first into a serial display chain
//   clk, rst_n          : system clock, async active-low reset
//   start               : frame request, taken only while idle
//   hexs/points/LEs     : per-digit hex value, decimal point, enable (captured at start)
//   sclk/sdata/slatch   : 3-wire link to the shift-register chain
//   busy/done           : frame in progress / one-cycle end-of-frame pulse
module seg_serial_tx #(
    parameter int DIGITS         = 8,
    parameter int CLK_DIV        = 4,
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     LEs,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  slatch,
    output logic                  busy,
    output logic                  done
);
    localparam int BITS = 8 * DIGITS;
    localparam int CW   = $clog2(BITS + 1);
    localparam int DW   = $clog2(CLK_DIV + 1);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] hex_q, hex_d;
    logic [DIGITS-1:0]   pts_q, pts_d, les_q, les_d;
    logic [BITS-1:0]     sr_q, sr_d, frame;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       div_q, div_d;
    logic                sclk_q, sclk_d, sdata_q, sdata_d, slatch_q, slatch_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [7:0]          seg_b;
    logic                div_last, bit_last;

    assign div_last = div_q == DW'(CLK_DIV - 1);
    assign bit_last = cnt_q == CW'(BITS - 1);

    // Digit DIGITS-1 lands in the top byte so it leaves first.
    always_comb begin
        frame = '0;
        seg_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_b = {pts_q[i], SEG_LUT[hex_q[4*i +: 4]]} & {8{les_q[i]}};
            frame[8*i +: 8] = (ACTIVE_LOW_SEG != 0) ? ~seg_b : seg_b;
        end
    end

    always_comb begin
        state_d = state_q;
        hex_d   = hex_q;
        pts_d   = pts_q;
        les_d   = les_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                hex_d   = hexs;
                pts_d   = points;
                les_d   = LEs;
            end
            LOAD: begin
                state_d = SHIFT_LO;
                sr_d    = frame;
                cnt_d   = '0;
                div_d   = '0;
            end
            SHIFT_LO: begin
                div_d   = div_last ? '0 : div_q + DW'(1);
                state_d = div_last ? SHIFT_HI : SHIFT_LO;
            end
            SHIFT_HI: begin
                div_d = div_last ? '0 : div_q + DW'(1);
                if (div_last) begin
                    sr_d    = sr_q << 1;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = bit_last ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                div_d   = div_last ? '0 : div_q + DW'(1);
                state_d = div_last ? IDLE : LATCH;
            end
            default: state_d = IDLE;
        endcase
        // Outputs follow the next state so they come straight from flops.
        sclk_d   = state_d == SHIFT_HI;
        slatch_d = state_d == LATCH;
        busy_d   = state_d != IDLE;
        done_d   = state_q == LATCH && state_d == IDLE;
        sdata_d  = state_d == SHIFT_LO ? sr_d[BITS-1] : sdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hex_q    <= '0;
            pts_q    <= '0;
            les_q    <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            div_q    <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            slatch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hex_q    <= hex_d;
            pts_q    <= pts_d;
            les_q    <= les_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            slatch_q <= slatch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sclk   = sclk_q;
    assign sdata  = sdata_q;
    assign slatch = slatch_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_seg_serial_tx.sv
// tb_seg_serial_tx: scoreboard bench for seg_serial_tx across three parameter sets
module tb_seg_serial_tx;
    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  st = '0;
    logic [31:0] hexs = '0;
    logic [7:0]  points = '0, les = '0;
    logic [2:0]  sclk_v, sdata_v, slatch_v, busy_v, done_v;
    int          sel = 0;
    logic        sclk_m, sdata_m, slatch_m, busy_m, done_m;

    int          checks = 0, errors = 0;
    logic [7:0]  exp_q [$];
    logic        bits_q [$];
    int          busy_n, lat_hi, lat_pulses, stab_err, toggles, iters;
    int          chg_at = 0, pulse_at = 0;
    logic [31:0] chg_val = '0;
    logic        first_busy, timed_out;
    bit          hold = 0;

    seg_serial_tx #(.DIGITS(8), .CLK_DIV(2), .ACTIVE_LOW_SEG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .hexs(hexs), .points(points), .LEs(les),
        .sclk(sclk_v[0]), .sdata(sdata_v[0]), .slatch(slatch_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    seg_serial_tx #(.DIGITS(8), .CLK_DIV(2), .ACTIVE_LOW_SEG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .hexs(hexs), .points(points), .LEs(les),
        .sclk(sclk_v[1]), .sdata(sdata_v[1]), .slatch(slatch_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    seg_serial_tx #(.DIGITS(8), .CLK_DIV(1), .ACTIVE_LOW_SEG(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .hexs(hexs), .points(points), .LEs(les),
        .sclk(sclk_v[2]), .sdata(sdata_v[2]), .slatch(slatch_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    always #5 clk = ~clk;

    assign sclk_m   = sclk_v[sel];
    assign sdata_m  = sdata_v[sel];
    assign slatch_m = slatch_v[sel];
    assign busy_m   = busy_v[sel];
    assign done_m   = done_v[sel];

    function automatic void push_model(logic [31:0] h, logic [7:0] p, logic [7:0] l, bit als);
        logic [7:0] b;
        for (int i = 7; i >= 0; i--) begin
            b = l[i] ? {p[i], SEG[h[4*i +: 4]]} : 8'h00;
            exp_q.push_back(als ? ~b : b);
        end
    endfunction

    function automatic logic [7:0] got_byte(int j);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[7-k] = bits_q[8*j+k];
        return b;
    endfunction

    // Samples the selected DUT at each negedge until done or a cycle budget runs out.
    task automatic collect();
        logic ps, pl, lo_d, hi_d;
        bits_q.delete();
        busy_n = 0; lat_hi = 0; lat_pulses = 0; stab_err = 0; toggles = 0; iters = 0;
        ps = sclk_m; pl = slatch_m; lo_d = sdata_m; hi_d = sdata_m;
        timed_out = 1'b1; first_busy = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (!hold) st = '0;
            if (c == chg_at) hexs = chg_val;
            if (c == pulse_at) st[sel] = 1'b1;
            if (c == 1) first_busy = busy_m;
            if (busy_m) busy_n++;
            if (sclk_m !== ps) toggles++;
            if (sclk_m && !ps) begin
                bits_q.push_back(sdata_m);
                if (sdata_m !== lo_d) stab_err++;
                hi_d = sdata_m;
            end else if (sclk_m && sdata_m !== hi_d) stab_err++;
            if (!sclk_m) lo_d = sdata_m;
            if (slatch_m) lat_hi++;
            if (slatch_m && !pl) lat_pulses++;
            ps = sclk_m; pl = slatch_m;
            if (done_m) begin
                iters = c;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic go();
        @(negedge clk);
        st[sel] = 1'b1;
        collect();
    endtask

    task automatic test_reset();
        logic [4:0] o;
        int lat_seen;
        sel = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sclk_v, sdata_v, slatch_v, busy_v, done_v} !== 15'h0) begin
            errors++; $display("FAIL reset_state got %h exp 0", {sclk_v, sdata_v, slatch_v, busy_v, done_v});
        end
        rst_n = 1'b1;
        hexs = 32'hFFFFFFFF; points = 8'hFF; les = 8'hFF;
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        repeat (60) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 o = {sclk_v[0], sdata_v[0], slatch_v[0], busy_v[0], done_v[0]};
        checks++;
        if (o !== 5'h0) begin
            errors++; $display("FAIL reset_async got %b exp 00000", o);
        end
        lat_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (slatch_v[0] || busy_v[0]) lat_seen++;
        end
        checks++;
        if (lat_seen != 0) begin
            errors++; $display("FAIL reset_hold got %0d active cycles exp 0", lat_seen);
        end
        rst_n = 1'b1;
        hexs = 32'h5A3C96E1; points = 8'h42; les = 8'hDB;
        push_model(hexs, points, les, 1'b0);
        go();
        checks++;
        if (timed_out || busy_n != 259) begin
            errors++; $display("FAIL reset_frame busy got %0d exp 259 timeout %0d", busy_n, timed_out);
        end
        checks++;
        if (bits_q.size() != 64) begin
            errors++; $display("FAIL reset_frame bits got %0d exp 64", bits_q.size());
        end
        for (int j = 0; j < 8; j++) begin
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (got_byte(j) !== e) begin
                errors++; $display("FAIL reset_frame byte%0d got %h exp %h", j, got_byte(j), e);
            end
        end
    endtask

    task automatic test_decode();
        sel = 0;
        hexs = 32'h0123ABCD; points = 8'h01; les = 8'hFF;
        exp_q.push_back(8'h3F); exp_q.push_back(8'h06); exp_q.push_back(8'h5B); exp_q.push_back(8'h4F);
        exp_q.push_back(8'h77); exp_q.push_back(8'h7C); exp_q.push_back(8'h39); exp_q.push_back(8'hDE);
        go();
        checks++;
        if (bits_q.size() != 64) begin
            errors++; $display("FAIL decode bits got %0d exp 64", bits_q.size());
        end
        for (int j = 0; j < 8; j++) begin
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (got_byte(j) !== e) begin
                errors++; $display("FAIL decode byte%0d got %h exp %h", j, got_byte(j), e);
            end
        end
        checks++;
        if (timed_out || busy_n != 259) begin
            errors++; $display("FAIL decode busy got %0d exp 259 timeout %0d", busy_n, timed_out);
        end
        checks++;
        if (lat_pulses != 1 || lat_hi != 2) begin
            errors++; $display("FAIL decode latch got pulses %0d width %0d exp 1 2", lat_pulses, lat_hi);
        end
        checks++;
        if (stab_err != 0) begin
            errors++; $display("FAIL decode sdata_stable got %0d violations exp 0", stab_err);
        end
        @(negedge clk);
        checks++;
        if (done_m !== 1'b0 || busy_m !== 1'b0) begin
            errors++; $display("FAIL decode done_width got done %b busy %b exp 0 0", done_m, busy_m);
        end
    endtask

    task automatic test_active_low();
        sel = 1;
        hexs = 32'h88888888; points = 8'h00; les = 8'h7F;
        exp_q.push_back(8'hFF);
        repeat (7) exp_q.push_back(8'h80);
        go();
        checks++;
        if (bits_q.size() != 64) begin
            errors++; $display("FAIL active_low bits got %0d exp 64", bits_q.size());
        end
        for (int j = 0; j < 8; j++) begin
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (got_byte(j) !== e) begin
                errors++; $display("FAIL active_low byte%0d got %h exp %h", j, got_byte(j), e);
            end
        end
    endtask

    task automatic test_capture();
        sel = 1;
        hexs = 32'h11111111; points = 8'h00; les = 8'hFF;
        repeat (8) exp_q.push_back(8'hF9);
        chg_at = 100; chg_val = 32'h22222222;
        go();
        chg_at = 0;
        checks++;
        if (bits_q.size() != 64 || timed_out) begin
            errors++; $display("FAIL capture bits got %0d exp 64 timeout %0d", bits_q.size(), timed_out);
        end
        for (int j = 0; j < 8; j++) begin
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (got_byte(j) !== e) begin
                errors++; $display("FAIL capture byte%0d got %h exp %h", j, got_byte(j), e);
            end
        end
    endtask

    task automatic test_handshake();
        int extra;
        sel = 0;
        hexs = 32'hFEDC0123; points = 8'hA5; les = 8'hEE;
        push_model(hexs, points, les, 1'b0);
        pulse_at = 50;
        go();
        pulse_at = 0;
        for (int j = 0; j < 8; j++) begin
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (got_byte(j) !== e) begin
                errors++; $display("FAIL handshake byte%0d got %h exp %h", j, got_byte(j), e);
            end
        end
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_m || busy_m) extra++;
        end
        checks++;
        if (timed_out || extra != 0) begin
            errors++; $display("FAIL handshake ignored got %0d active cycles exp 0 timeout %0d", extra, timed_out);
        end
    endtask

    task automatic test_stream();
        sel = 0;
        hexs = $urandom; points = 8'($urandom); les = 8'($urandom);
        push_model(hexs, points, les, 1'b0);
        push_model(hexs, points, les, 1'b0);
        hold = 1;
        go();
        checks++;
        if (timed_out || iters != 260) begin
            errors++; $display("FAIL stream first_done got %0d cycles exp 260", iters);
        end
        for (int j = 0; j < 8; j++) begin
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (got_byte(j) !== e) begin
                errors++; $display("FAIL stream f1 byte%0d got %h exp %h", j, got_byte(j), e);
            end
        end
        hold = 0;
        collect();
        checks++;
        if (first_busy !== 1'b1) begin
            errors++; $display("FAIL stream rebusy got %b exp 1", first_busy);
        end
        checks++;
        if (timed_out || iters != 260 || busy_n != 259) begin
            errors++; $display("FAIL stream period got %0d busy %0d exp 260 259", iters, busy_n);
        end
        for (int j = 0; j < 8; j++) begin
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (got_byte(j) !== e) begin
                errors++; $display("FAIL stream f2 byte%0d got %h exp %h", j, got_byte(j), e);
            end
        end
    endtask

    task automatic test_timing();
        sel = 2;
        hexs = 32'h9B4E07C2; points = 8'h3C; les = 8'hF5;
        push_model(hexs, points, les, 1'b1);
        go();
        checks++;
        if (timed_out || busy_n != 1 + 2*1*64 + 1) begin
            errors++; $display("FAIL timing busy got %0d exp %0d", busy_n, 1 + 2*1*64 + 1);
        end
        checks++;
        if (toggles != 128 || stab_err != 0) begin
            errors++; $display("FAIL timing sclk got toggles %0d stab %0d exp 128 0", toggles, stab_err);
        end
        checks++;
        if (lat_pulses != 1 || lat_hi != 1) begin
            errors++; $display("FAIL timing latch got %0d/%0d exp 1/1", lat_pulses, lat_hi);
        end
        for (int j = 0; j < 8; j++) begin
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (got_byte(j) !== e) begin
                errors++; $display("FAIL timing byte%0d got %h exp %h", j, got_byte(j), e);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            sel = n % 2;
            hexs = $urandom; points = 8'($urandom); les = 8'($urandom);
            push_model(hexs, points, les, sel == 1);
            go();
            checks++;
            if (timed_out || busy_n != 259) begin
                errors++; $display("FAIL random%0d busy got %0d exp 259", n, busy_n);
            end
            for (int j = 0; j < 8; j++) begin
                logic [7:0] e = exp_q.pop_front();
                checks++;
                if (got_byte(j) !== e) begin
                    errors++; $display("FAIL random%0d byte%0d got %h exp %h", n, j, got_byte(j), e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_active_low();
        test_capture();
        test_handshake();
        test_stream();
        test_timing();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
